mac_arbiter: RTL

- Time-shares one pipelined signed 32x32 multiplier with dequantising shift among N requesters (FIR tap engines, demod and mult stages of the FM radio datapath).
- Round-robin arbitration; at most one operand pair accepted per cycle.
- Each product returns after a fixed latency, tagged one-hot to the requester that issued it.
- Lets the FIR/mult blocks drop private multipliers and cut DSP usage.

---
 rtl/mac_arbiter_pkg.sv | 20 ++
 rtl/mac_arbiter_rr_arbiter.sv | 101 ++++++++++
 rtl/mac_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mac_arbiter_pkg.sv
// mac_arbiter_pkg
//   Shared widths, signed word/product types and the dequantise helper for the
//   multiplier arbiter.
//   Optional feature macro: MAC_ARBITER_LOCK_EN (see rr_arbiter / mac_arbiter).
package mac_arbiter_pkg;

  localparam int MAC_DATA_WIDTH = 32;
  localparam int MAC_QUANT_BITS = 10;

  typedef logic signed [MAC_DATA_WIDTH-1:0]   word_t;
  typedef logic signed [2*MAC_DATA_WIDTH-1:0] product_t;

  // Arithmetic shift floors toward -inf; the upper bits are dropped, so overflow wraps.
  function automatic word_t dequantise(product_t p);
    product_t shifted;
    shifted = p >>> MAC_QUANT_BITS;
    return shifted[MAC_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mac_arbiter_rr_arbiter.sv
// rr_arbiter
//   Round-robin grant generator with wrap-around priority search and rr_ptr.
//   With MAC_ARBITER_LOCK_EN defined, a handshake without req_last pins the
//   grant to that requester until its req_last handshake.
//
//   state    | meaning
//   unlocked | search starts at rr_ptr, first valid requester wins
//   locked   | only lock_idx may be granted, others see ready low
//
// Ports
//   clock, reset : system clock, synchronous active-high reset
//   req_valid    : per-requester request
//   req_last     : per-requester end of burst (MAC_ARBITER_LOCK_EN only)
//   grant        : one-hot grant, already qualified by req_valid
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef MAC_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0] req_last,
`endif
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   search_idx;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] search_grant;
  logic               found;

  // First pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0..rr_ptr-1.
  always_comb begin
    search_grant = '0;
    search_idx   = '0;
    found        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
        found           = 1'b1;
        search_grant[i] = 1'b1;
        search_idx      = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found           = 1'b1;
        search_grant[i] = 1'b1;
        search_idx      = PTR_W'(i);
      end
    end
  end

`ifdef MAC_ARBITER_LOCK_EN
  logic             lock_active;
  logic [PTR_W-1:0] lock_idx;
  logic             last_hit;

  always_comb begin
    grant = '0;
    if (lock_active) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((PTR_W'(i) == lock_idx) && req_valid[i]) grant[i] = 1'b1;
      end
    end else begin
      grant = search_grant;
    end
  end

  assign grant_idx = lock_active ? lock_idx : search_idx;
  assign last_hit  = |(grant & req_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (|grant) begin
      if (lock_active) begin
        if (last_hit) lock_active <= 1'b0;
      end else if (!last_hit) begin
        lock_active <= 1'b1;
        lock_idx    <= grant_idx;
      end
    end
  end
`else
  assign grant     = search_grant;
  assign grant_idx = search_idx;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter
//   Shares one pipelined signed multiply + dequantising shift among NUM_REQ
//   requesters. One handshake per cycle, response exactly 3 cycles later,
//   tagged one-hot to the issuing requester. No response backpressure.
//   Optional feature macro: MAC_ARBITER_LOCK_EN adds req_last burst locking.
//
// Ports
//   clock, reset : system clock, synchronous active-high reset
//   req_valid    : requester i presents an operand pair
//   req_a, req_b : packed signed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     : end of locked burst (MAC_ARBITER_LOCK_EN only)
//   req_ready    : one-hot grant
//   rsp_valid    : one-hot response owner
//   rsp_data     : dequantised product
//   busy         : any transaction in the pipeline
module mac_arbiter
  import mac_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = MAC_DATA_WIDTH,
  parameter int QUANT_BITS  = MAC_QUANT_BITS,
  parameter int PIPE_STAGES = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
`ifdef MAC_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  logic [NUM_REQ-1:0]             grant;
  logic [DATA_WIDTH-1:0]          sel_a, sel_b;
  logic [DATA_WIDTH-1:0]          s1_a, s1_b;
  logic [2*DATA_WIDTH-1:0]        ext_a, ext_b;
  logic signed [2*DATA_WIDTH-1:0] s2_prod;
  logic [DATA_WIDTH-1:0]          deq;
  logic [NUM_REQ-1:0]             tag_pipe [PIPE_STAGES];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
`ifdef MAC_ARBITER_LOCK_EN
    .req_last  (req_last),
`endif
    .grant     (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Sign-extending to full width first keeps the low 2*DATA_WIDTH product bits exact.
  assign ext_a = {{DATA_WIDTH{s1_a[DATA_WIDTH-1]}}, s1_a};
  assign ext_b = {{DATA_WIDTH{s1_b[DATA_WIDTH-1]}}, s1_b};

  generate
    if (DATA_WIDTH == MAC_DATA_WIDTH && QUANT_BITS == MAC_QUANT_BITS) begin : g_pkg_deq
      assign deq = dequantise(s2_prod);
    end else begin : g_gen_deq
      logic signed [2*DATA_WIDTH-1:0] shifted;
      assign shifted = s2_prod >>> QUANT_BITS;
      assign deq     = shifted[DATA_WIDTH-1:0];
    end
  endgenerate

  // The tag shift doubles as the stage-valid chain: a stage is valid when its tag is non-zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < PIPE_STAGES; s++) tag_pipe[s] <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_prod  <= '0;
      rsp_data <= '0;
    end else begin
      tag_pipe[0] <= grant;
      for (int s = 1; s < PIPE_STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
      if (|grant) begin
        s1_a <= sel_a;
        s1_b <= sel_b;
      end
      if (|tag_pipe[0]) s2_prod  <= ext_a * ext_b;
      if (|tag_pipe[1]) rsp_data <= deq;
    end
  end

  assign rsp_valid = tag_pipe[PIPE_STAGES-1];

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < PIPE_STAGES; s++) busy = busy | (|tag_pipe[s]);
  end

endmodule
